dm_port_arbiter: RTL and testbench

//  Shares the single-port data memory between the pipeline MEM stage and a debug/loader port.

---
 rtl/dm_port_arbiter.sv | 104 ++++++++++
 tb/tb_dm_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter.sv
// Shares the single-port data memory between the MEM stage and a debug/loader port.
// CPU has priority; a waiting debug request is force-granted (with a pipeline stall) after MAX_WAIT cycles.
module dm_port_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_mem_read,
  input  logic        cpu_mem_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_read,
  output logic        dm_write,
  input  logic [31:0] dm_rdata
);

  typedef enum logic [0:0] {
    CPU_OWN = 1'b0,
    DBG_ACK = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_nxt;
  logic             cpu_act;
  logic             grant;

  assign cpu_act = cpu_mem_read | cpu_mem_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CPU_OWN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    grant        = 1'b0;
    case (state)
      CPU_OWN: begin
        grant = dbg_req & (~cpu_act | (wait_cnt >= WAIT_LIMIT));
        if (grant) begin
          state_nxt    = DBG_ACK;
          wait_cnt_nxt = '0;
        end else if (dbg_req & cpu_act) begin
          if (wait_cnt != CNT_MAX) wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end else if (!dbg_req) begin
          // covers an abandoned request as well as the idle case
          wait_cnt_nxt = '0;
        end
      end
      // dbg_req is deliberately ignored here so the CPU always gets this slot
      DBG_ACK: state_nxt = CPU_OWN;
      default: state_nxt = CPU_OWN;
    endcase
  end

  always_comb begin
    if (grant) begin
      dm_addr  = dbg_addr;
      dm_wdata = dbg_wdata;
      dm_write = ~rst & dbg_we;
      dm_read  = ~rst & ~dbg_we;
    end else begin
      dm_addr  = cpu_addr;
      dm_wdata = cpu_wdata;
      dm_write = ~rst & cpu_mem_write;
      dm_read  = ~rst & cpu_mem_read & ~cpu_mem_write;
    end
  end

  assign cpu_stall = ~rst & grant & cpu_act;
  assign cpu_rdata = dm_rdata;
  assign dbg_ack   = (state == DBG_ACK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_rdata <= '0;
    end else if (grant & ~dbg_we) begin
      dbg_rdata <= dm_rdata;
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: directed scenarios followed by randomized traffic,
// all checked against a cycle-level reference model with its own memory image.
module tb_dm_port_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_mem_read, cpu_mem_write;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dbg_req, dbg_we;
  logic [31:0] dbg_addr, dbg_wdata;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_read, dm_write;

  always #5 clk = ~clk;

  dm_port_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_read(dm_read), .dm_write(dm_write),
    .dm_rdata(dm_rdata)
  );

  // Data memory attached to the DUT
  logic [31:0] tb_mem [0:255];
  assign dm_rdata = tb_mem[dm_addr[9:2]];
  always @(posedge clk) if (dm_write) tb_mem[dm_addr[9:2]] <= dm_wdata;

  // Reference model state
  logic [31:0] ref_mem [0:255];
  bit          m_ack;
  int          m_waited;
  logic [31:0] m_dbg_rdata;

  // Per-cycle predictions
  bit          p_act, p_grant, p_read, p_write, p_stall;
  logic [31:0] p_addr, p_wdata;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic predict_and_check();
    p_act   = cpu_mem_read || cpu_mem_write;
    p_grant = !rst && !m_ack && dbg_req && (!p_act || m_waited >= MAX_WAIT);
    if (p_grant) begin
      p_addr = dbg_addr; p_wdata = dbg_wdata;
      p_write = dbg_we;  p_read = !dbg_we;
    end else begin
      p_addr = cpu_addr; p_wdata = cpu_wdata;
      p_write = cpu_mem_write; p_read = cpu_mem_read && !cpu_mem_write;
    end
    if (rst) begin
      p_write = 1'b0; p_read = 1'b0;
    end
    p_stall = p_grant && p_act;
    chk("dm_write", dm_write, p_write);
    chk("dm_read", dm_read, p_read);
    chk("cpu_stall", cpu_stall, p_stall);
    chk("dbg_ack", dbg_ack, (!rst && m_ack));
    chk("dbg_rdata", dbg_rdata, rst ? 32'h0 : m_dbg_rdata);
    if (!rst) begin
      chk("dm_addr", dm_addr, p_addr);
      chk("dm_wdata", dm_wdata, p_wdata);
      chk("cpu_rdata", cpu_rdata, ref_mem[p_addr[9:2]]);
    end
  endtask

  task automatic cyc_begin();
    @(negedge clk);
    predict_and_check();
  endtask

  task automatic commit();
    @(posedge clk);
    if (rst) begin
      m_ack = 0; m_waited = 0; m_dbg_rdata = 32'h0;
    end else begin
      if (p_grant && !dbg_we) m_dbg_rdata = ref_mem[dbg_addr[9:2]];
      if (p_write) ref_mem[p_addr[9:2]] = p_wdata;
      if (p_grant) begin
        m_ack = 1; m_waited = 0;
      end else if (m_ack) begin
        m_ack = 0;
      end else if (dbg_req && p_act) begin
        m_waited = (m_waited < 255) ? m_waited + 1 : 255;
      end else if (!dbg_req) begin
        m_waited = 0;
      end
    end
    #1;
  endtask

  task automatic set_cpu(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    cpu_mem_read = rd; cpu_mem_write = wr; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_dbg(input bit rq, input bit we, input logic [31:0] a, input logic [31:0] d);
    dbg_req = rq; dbg_we = we; dbg_addr = a; dbg_wdata = d;
  endtask

  initial begin
    int busy_pct;
    bit last_ack, last_stall;
    int op;

    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = 32'hA500_0000 | 32'(i);
      ref_mem[i] = 32'hA500_0000 | 32'(i);
    end
    m_ack = 0; m_waited = 0; m_dbg_rdata = 32'h0;

    // Reset with every request active: nothing may reach the DM
    rst = 1'b1;
    set_cpu(1, 1, 32'h0000_0004, 32'h1111_1111);
    set_dbg(1, 1, 32'h0000_0008, 32'h2222_2222);
    cyc_begin();
    chk("rst_dm_write", dm_write, 1'b0);
    chk("rst_stall", cpu_stall, 1'b0);
    chk("rst_ack", dbg_ack, 1'b0);
    chk("rst_dbg_rdata", dbg_rdata, 32'h0);
    commit();
    chk("rst_no_commit", tb_mem[1], 32'hA500_0001);
    rst = 1'b0;
    set_cpu(0, 0, 32'h0, 32'h0);
    set_dbg(0, 0, 32'h0, 32'h0);
    cyc_begin(); commit();

    // T1: idle CPU, debug write
    set_dbg(1, 1, 32'h10, 32'hCAFE_F00D);
    cyc_begin();
    chk("t1_grant_write", dm_write, 1'b1);
    chk("t1_grant_addr", dm_addr, 32'h10);
    chk("t1_no_stall", cpu_stall, 1'b0);
    commit();
    cyc_begin();
    chk("t1_ack", dbg_ack, 1'b1);
    chk("t1_ack_stall", cpu_stall, 1'b0);
    commit();
    set_dbg(0, 0, 32'h0, 32'h0);
    cyc_begin(); commit();

    // T2: debug read back
    set_dbg(1, 0, 32'h10, 32'h0);
    cyc_begin();
    chk("t2_grant_read", dm_read, 1'b1);
    commit();
    cyc_begin();
    chk("t2_ack", dbg_ack, 1'b1);
    chk("t2_rdata", dbg_rdata, 32'hCAFE_F00D);
    commit();
    set_dbg(0, 0, 32'h0, 32'h0);
    cyc_begin();
    chk("t2_ack_drop", dbg_ack, 1'b0);
    chk("t2_rdata_held", dbg_rdata, 32'hCAFE_F00D);
    commit();

    // T3: CPU loads every cycle, debug waits MAX_WAIT cycles
    set_cpu(1, 0, 32'h40, 32'h0);
    set_dbg(1, 0, 32'h10, 32'h0);
    for (int k = 0; k < MAX_WAIT; k++) begin
      cyc_begin();
      chk("t3_wait_stall", cpu_stall, 1'b0);
      chk("t3_wait_addr", dm_addr, 32'h40);
      commit();
    end
    cyc_begin();
    chk("t3_forced_stall", cpu_stall, 1'b1);
    chk("t3_forced_addr", dm_addr, 32'h10);
    commit();
    cyc_begin();
    chk("t3_ack", dbg_ack, 1'b1);
    chk("t3_ack_no_stall", cpu_stall, 1'b0);
    chk("t3_cpu_serviced", dm_read, 1'b1);
    chk("t3_cpu_addr", dm_addr, 32'h40);
    commit();
    set_dbg(0, 0, 32'h0, 32'h0);
    set_cpu(0, 0, 32'h0, 32'h0);
    cyc_begin(); commit();

    // T4: CPU store and debug request together; store goes first
    set_cpu(0, 1, 32'h20, 32'h1);
    set_dbg(1, 0, 32'h20, 32'h0);
    cyc_begin();
    chk("t4_cpu_write", dm_write, 1'b1);
    chk("t4_cpu_addr", dm_addr, 32'h20);
    chk("t4_no_stall", cpu_stall, 1'b0);
    commit();
    chk("t4_committed", tb_mem[8], 32'h1);
    set_cpu(1, 0, 32'h44, 32'h0);
    for (int k = 1; k < MAX_WAIT; k++) begin
      cyc_begin();
      chk("t4_wait_stall", cpu_stall, 1'b0);
      commit();
    end
    cyc_begin();
    chk("t4_forced_stall", cpu_stall, 1'b1);
    commit();
    cyc_begin();
    chk("t4_ack", dbg_ack, 1'b1);
    chk("t4_rdata", dbg_rdata, 32'h1);
    commit();
    set_dbg(0, 0, 32'h0, 32'h0);
    set_cpu(0, 0, 32'h0, 32'h0);
    cyc_begin(); commit();

    // T5: reset during a debug write grant
    set_dbg(1, 1, 32'h30, 32'hDEAD_BEEF);
    cyc_begin();
    chk("t5_grant_write", dm_write, 1'b1);
    rst = 1'b1;
    #1;
    predict_and_check();
    chk("t5_rst_write", dm_write, 1'b0);
    chk("t5_rst_ack", dbg_ack, 1'b0);
    commit();
    chk("t5_mem_unchanged", tb_mem[12], 32'hA500_000C);
    chk("t5_ack_lost", dbg_ack, 1'b0);
    rst = 1'b0;
    set_dbg(0, 0, 32'h0, 32'h0);
    cyc_begin(); commit();

    // T6: read and write together -> write wins
    set_cpu(1, 1, 32'h50, 32'h5A5A_5A5A);
    cyc_begin();
    chk("t6_write", dm_write, 1'b1);
    chk("t6_read", dm_read, 1'b0);
    commit();
    chk("t6_committed", tb_mem[20], 32'h5A5A_5A5A);
    set_cpu(0, 0, 32'h0, 32'h0);

    // Randomized traffic
    last_ack = 0; last_stall = 0;
    for (int c = 0; c < 800; c++) begin
      case ((c / 200) % 4)
        0: busy_pct = 90;
        1: busy_pct = 50;
        2: busy_pct = 100;
        default: busy_pct = 20;
      endcase
      if (!last_stall) begin
        if ($urandom_range(0, 99) < busy_pct) begin
          op = $urandom_range(0, 2);
          set_cpu(op != 1, op != 0, 32'($urandom_range(0, 15)) << 2, $urandom);
        end else begin
          set_cpu(0, 0, 32'($urandom_range(0, 15)) << 2, $urandom);
        end
      end
      if (last_ack) begin
        dbg_req = 0;
      end else if (!dbg_req) begin
        if ($urandom_range(0, 3) == 0)
          set_dbg(1, $urandom_range(0, 1) == 1, 32'($urandom_range(0, 15)) << 2, $urandom);
      end else if ($urandom_range(0, 49) == 0) begin
        dbg_req = 0;
      end
      cyc_begin();
      last_ack = m_ack;
      last_stall = p_stall;
      commit();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
